id_hazard_branch_ctrl: RTL and testbench
========================================

# id_hazard_branch_ctrl

Hazard and branch-resolution control for the ID stage of the 5-stage MIPS32 pipeline. It sits directly upstream of the ID register-read compare logic and drives its two WB-forward selects. It consumes the equality result that logic returns and produces the PC-source, stall, bubble and IF/ID flush controls. A 3-entry destination-register shadow pipeline (EX/MEM/WB) is kept internally, so the block needs only the decoded fields of the instruction currently in ID.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- ZERO_REG, 5'd0, architectural zero register; never a dependency

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Freeze  in  1  global pipeline hold (memory wait); shadow and all state hold
- Instr_Valid_ID  in  1  ID holds a real instruction
- Rs_ID, Rt_ID  in  5  source registers of the instruction in ID
- Uses_Rs_ID, Uses_Rt_ID  in  1  source actually read
- Write_Reg_ID  in  5  destination of the instruction in ID
- Reg_Write_ID, Mem_Read_ID  in  1  instruction in ID writes a register / is a load
- Branch_ID, Branch_NE_ID  in  1  instruction is BEQ / BNE
- Comparetor_ID  in  1  forwarded operands equal
- Forward_C_ID, Forward_D_ID  out  1  select Write_Data_WB for operand 1 / 2
- Stall_ID  out  1  hold PC and IF/ID
- Bubble_EX  out  1  zero ID/EX control on next edge (equals Stall_ID)
- PC_Src_ID  out  1  branch taken; PC loads branch target
- Flush_IF_ID  out  1  IF/ID loads NOP on next edge

## Operation
- Shadow entries hold {Write_Reg, Reg_Write, Mem_Read}, named SH_EX, SH_MEM, SH_WB.
- Match on X for src S: Uses_S_ID && S != ZERO_REG && X.Reg_Write && X.Write_Reg == S.
- Forward_C_ID asserts on match on SH_WB for Rs. Forward_D_ID asserts on match on SH_WB for Rt. Both are gated by Instr_Valid_ID.
- Branch hazard (Branch_ID or Branch_NE_ID): stall on any match on SH_EX or SH_MEM. This gives 2 stall cycles for an EX producer and 1 for a MEM producer. A WB producer needs no stall because it is forwarded.
- Non-branch hazard: stall only on a match on SH_EX where SH_EX.Mem_Read is set (load-use, 1 cycle). All other cases are handled by EX forwarding.
- Stall_ID = Instr_Valid_ID && hazard && !Freeze.
- Taken = Instr_Valid_ID && !Stall_ID && !Freeze && ((Branch_ID && Comparetor_ID) || (!Branch_ID && Branch_NE_ID && !Comparetor_ID)).
  - If both Branch_ID and Branch_NE_ID are set, Branch_ID has priority.
- PC_Src_ID = Taken.
- Shadow update on an edge:
  - Freeze: all entries hold.
  - Otherwise SH_WB <= SH_MEM and SH_MEM <= SH_EX.
  - SH_EX <= bubble (all zero) if Stall_ID or !Instr_Valid_ID, else the ID fields.
- The FSM is implicit in the shadow. Stall length is self-timing: the stall clears as the producer advances.

## Timing
- Reset (asynchronous assert, synchronous release): all shadow entries zero; every output 0.
- All outputs are combinational from the current shadow and ID inputs, valid in the same cycle. There are no registered outputs.
- Taken at cycle t: the PC target is loaded at edge t+1. The IF/ID instruction fetched in t is squashed per Configuration.
- Stall and taken are mutually exclusive by construction. A stalled branch re-evaluates every cycle.
- Freeze dominates: when set, Stall_ID, PC_Src_ID and Flush_IF_ID are all 0 and no state moves.
- Reset asserted mid-stall clears the shadow. The first cycle after release has no hazards.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: MIPS delay-slot semantics. Flush_IF_ID is tied to 0 and the slot instruction executes.
- BRANCH_DELAY_SLOT_EN undefined: Flush_IF_ID = Taken, and one bubble follows every taken branch.

## Structure
- Shared package (hazard_pkg): the shadow-entry struct {Write_Reg, Reg_Write, Mem_Read}, the bubble constant and ZERO_REG.
- One sub-module, hazard_src_match: compares one source against one shadow entry. It is instantiated 6 times (2 sources × EX/MEM/WB).
- The top level holds the shadow flops, the stall/taken logic and the macro branch.

## Test plan
- ADD $3 in ID, then BEQ $3,$4 -> Stall_ID=1 for 2 cycles, then Forward_C_ID=1. With Comparetor_ID=1: PC_Src_ID=1, and Flush_IF_ID=1 only without the macro.
- LW $5, then ADD uses $5 -> Stall_ID=1 and Bubble_EX=1 for exactly 1 cycle; SH_EX holds the bubble.
- Producer writes $0, then BNE $0 -> no stall and no forward; the branch is taken when Comparetor_ID=0.
- Branch_ID=Branch_NE_ID=1 with Comparetor_ID=0 -> PC_Src_ID=0 (BEQ priority).
- Stall pending and Freeze=1 for 3 cycles -> Stall_ID=0 and the shadow is unchanged. On release, the remaining stall count is unchanged.
- Reset_n pulsed low mid-stall -> all outputs 0 immediately. After release the same BEQ resolves with no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard/branch control: destination-register
// shadow entry layout, the bubble value and the architectural zero register.
package hazard_pkg;

  localparam int SH_REG_W = 5;
  localparam logic [SH_REG_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [SH_REG_W-1:0] Write_Reg;
    logic                Reg_Write;
    logic                Mem_Read;
  } sh_entry_t;

  localparam sh_entry_t SH_BUBBLE = '0;

endpackage

// File: rtl/hazard_src_match.sv
// Dependency check of one ID source register against one in-flight producer.
// Register $0 never creates a dependency.
module hazard_src_match #(
  parameter int                    REG_ADDR_W = 5,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = REG_ADDR_W'(hazard_pkg::ZERO_REG)
) (
  input  logic                  uses_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] wr_reg_i,
  input  logic                  reg_write_i,
  output logic                  match_o
);

  assign match_o = uses_i && (src_i != ZERO_REG) && reg_write_i && (wr_reg_i == src_i);

endmodule

// File: rtl/id_hazard_branch_ctrl.sv
// ID-stage stall, WB-forward and branch-resolution control for the 5-stage
// MIPS32 pipeline. Define BRANCH_DELAY_SLOT_EN for delay-slot semantics.
module id_hazard_branch_ctrl #(
  parameter int                    REG_ADDR_W = 5,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = REG_ADDR_W'(hazard_pkg::ZERO_REG)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Freeze,
  input  logic                  Instr_Valid_ID,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic                  Uses_Rs_ID,
  input  logic                  Uses_Rt_ID,
  input  logic [REG_ADDR_W-1:0] Write_Reg_ID,
  input  logic                  Reg_Write_ID,
  input  logic                  Mem_Read_ID,
  input  logic                  Branch_ID,
  input  logic                  Branch_NE_ID,
  input  logic                  Comparetor_ID,
  output logic                  Forward_C_ID,
  output logic                  Forward_D_ID,
  output logic                  Stall_ID,
  output logic                  Bubble_EX,
  output logic                  PC_Src_ID,
  output logic                  Flush_IF_ID
);

  import hazard_pkg::*;

  sh_entry_t sh_ex_q, sh_mem_q, sh_wb_q;
  sh_entry_t sh_ex_d;
  sh_entry_t id_entry;

  logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
  logic is_branch, hazard_ex, hazard_mem, hazard;
  logic stall, taken;

  assign id_entry = '{Write_Reg: Write_Reg_ID, Reg_Write: Reg_Write_ID, Mem_Read: Mem_Read_ID};

  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_rs_ex (
    .uses_i(Uses_Rs_ID), .src_i(Rs_ID), .wr_reg_i(sh_ex_q.Write_Reg),
    .reg_write_i(sh_ex_q.Reg_Write), .match_o(rs_ex));
  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_rt_ex (
    .uses_i(Uses_Rt_ID), .src_i(Rt_ID), .wr_reg_i(sh_ex_q.Write_Reg),
    .reg_write_i(sh_ex_q.Reg_Write), .match_o(rt_ex));
  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_rs_mem (
    .uses_i(Uses_Rs_ID), .src_i(Rs_ID), .wr_reg_i(sh_mem_q.Write_Reg),
    .reg_write_i(sh_mem_q.Reg_Write), .match_o(rs_mem));
  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_rt_mem (
    .uses_i(Uses_Rt_ID), .src_i(Rt_ID), .wr_reg_i(sh_mem_q.Write_Reg),
    .reg_write_i(sh_mem_q.Reg_Write), .match_o(rt_mem));
  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_rs_wb (
    .uses_i(Uses_Rs_ID), .src_i(Rs_ID), .wr_reg_i(sh_wb_q.Write_Reg),
    .reg_write_i(sh_wb_q.Reg_Write), .match_o(rs_wb));
  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_rt_wb (
    .uses_i(Uses_Rt_ID), .src_i(Rt_ID), .wr_reg_i(sh_wb_q.Write_Reg),
    .reg_write_i(sh_wb_q.Reg_Write), .match_o(rt_wb));

  // Branches compare in ID, so they wait for EX and MEM producers; other
  // instructions only wait on a load sitting in EX.
  assign is_branch  = Branch_ID || Branch_NE_ID;
  assign hazard_ex  = rs_ex || rt_ex;
  assign hazard_mem = rs_mem || rt_mem;
  assign hazard     = is_branch ? (hazard_ex || hazard_mem)
                                : (hazard_ex && sh_ex_q.Mem_Read);

  assign stall = Instr_Valid_ID && hazard && !Freeze;
  assign taken = Instr_Valid_ID && !stall && !Freeze &&
                 ((Branch_ID && Comparetor_ID) ||
                  (!Branch_ID && Branch_NE_ID && !Comparetor_ID));

  assign sh_ex_d = (stall || !Instr_Valid_ID) ? SH_BUBBLE : id_entry;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sh_ex_q  <= SH_BUBBLE;
      sh_mem_q <= SH_BUBBLE;
      sh_wb_q  <= SH_BUBBLE;
    end else if (!Freeze) begin
      sh_wb_q  <= sh_mem_q;
      sh_mem_q <= sh_ex_q;
      sh_ex_q  <= sh_ex_d;
    end
  end

  // Outputs are held low while reset is asserted, independent of ID inputs.
  assign Forward_C_ID = Reset_n && Instr_Valid_ID && rs_wb;
  assign Forward_D_ID = Reset_n && Instr_Valid_ID && rt_wb;
  assign Stall_ID     = Reset_n && stall;
  assign Bubble_EX    = Reset_n && stall;
  assign PC_Src_ID    = Reset_n && taken;

`ifdef BRANCH_DELAY_SLOT_EN
  assign Flush_IF_ID = 1'b0;
`else
  assign Flush_IF_ID = Reset_n && taken;
`endif

  logic unused_wb_mem_read;
  assign unused_wb_mem_read = sh_wb_q.Mem_Read;

endmodule

// File: tb/tb_id_hazard_branch_ctrl.sv
// Directed-vector bench for id_hazard_branch_ctrl; each scenario task checks
// {Forward_C, Forward_D, Stall, Bubble, PC_Src, Flush} against hand values.
module tb_id_hazard_branch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Freeze = 1'b0;
  logic       Instr_Valid_ID = 1'b0;
  logic [4:0] Rs_ID = '0, Rt_ID = '0, Write_Reg_ID = '0;
  logic       Uses_Rs_ID = 1'b0, Uses_Rt_ID = 1'b0;
  logic       Reg_Write_ID = 1'b0, Mem_Read_ID = 1'b0;
  logic       Branch_ID = 1'b0, Branch_NE_ID = 1'b0, Comparetor_ID = 1'b0;
  logic       Forward_C_ID, Forward_D_ID, Stall_ID, Bubble_EX, PC_Src_ID, Flush_IF_ID;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic FL = 1'b0;
`else
  localparam logic FL = 1'b1;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] obs, exp;

  assign obs = {Forward_C_ID, Forward_D_ID, Stall_ID, Bubble_EX, PC_Src_ID, Flush_IF_ID};

  id_hazard_branch_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Freeze(Freeze), .Instr_Valid_ID(Instr_Valid_ID),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID),
    .Write_Reg_ID(Write_Reg_ID), .Reg_Write_ID(Reg_Write_ID), .Mem_Read_ID(Mem_Read_ID),
    .Branch_ID(Branch_ID), .Branch_NE_ID(Branch_NE_ID), .Comparetor_ID(Comparetor_ID),
    .Forward_C_ID(Forward_C_ID), .Forward_D_ID(Forward_D_ID), .Stall_ID(Stall_ID),
    .Bubble_EX(Bubble_EX), .PC_Src_ID(PC_Src_ID), .Flush_IF_ID(Flush_IF_ID));

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic br,
                       input logic bne, input logic cmp);
    Instr_Valid_ID = v;  Rs_ID = rs;  Rt_ID = rt;  Uses_Rs_ID = urs;  Uses_Rt_ID = urt;
    Write_Reg_ID = wr;  Reg_Write_ID = rw;  Mem_Read_ID = mr;
    Branch_ID = br;  Branch_NE_ID = bne;  Comparetor_ID = cmp;
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    drive(1, 5'd3, 5'd4, 1, 1, 0, 0, 0, 1, 0, 1);
    exp = 6'b000000; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_outputs: got %b want %b", obs, exp); end
    tick(); tick();
    Reset_n = 1'b1; #1;
    exp = {5'b00001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_release_beq: got %b want %b", obs, exp); end
    drain();
  endtask

  task automatic test_branch_ex_dep();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 0);
    exp = 6'b000000; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_issue: got %b want %b", obs, exp); end
    tick();
    drive(1, 5'd3, 5'd4, 1, 1, 0, 0, 0, 1, 0, 1);
    exp = 6'b001100; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL beq_stall_ex: got %b want %b", obs, exp); end
    tick();
    exp = 6'b001100; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL beq_stall_mem: got %b want %b", obs, exp); end
    tick();
    exp = {5'b10001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL beq_fwd_taken: got %b want %b", obs, exp); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0);
    tick();
    drive(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 0, 0, 0, 0);
    exp = 6'b001100; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL load_use_stall: got %b want %b", obs, exp); end
    tick();
    exp = 6'b000000; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL load_use_release: got %b want %b", obs, exp); end
    tick();
    exp = 6'b100000; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL load_wb_forward: got %b want %b", obs, exp); end
    drain();
  endtask

  task automatic test_zero_reg();
    drive(1, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 1, 0);
    exp = {5'b00001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL bne_zero_ex: got %b want %b", obs, exp); end
    tick();
    exp = {5'b00001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL bne_zero_mem: got %b want %b", obs, exp); end
    tick();
    exp = {5'b00001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL bne_zero_wb: got %b want %b", obs, exp); end
    drain();
  endtask

  task automatic test_branch_priority();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    exp = 6'b000000; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL both_cmp0: got %b want %b", obs, exp); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    exp = {5'b00001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL both_cmp1: got %b want %b", obs, exp); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    exp = 6'b000000; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL beq_invalid: got %b want %b", obs, exp); end
    drain();
  endtask

  task automatic test_freeze();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0, 0, 0);
    tick();
    drive(1, 5'd8, 5'd7, 1, 1, 0, 0, 0, 1, 0, 1);
    exp = 6'b001100; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL frz_pre_stall: got %b want %b", obs, exp); end
    Freeze = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      exp = 6'b000000; vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL frz_hold%0d: got %b want %b", i, obs, exp); end
      tick();
    end
    Freeze = 1'b0; #1;
    exp = 6'b001100; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL frz_resume_ex: got %b want %b", obs, exp); end
    tick();
    exp = 6'b001100; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL frz_resume_mem: got %b want %b", obs, exp); end
    tick();
    exp = {5'b01001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL frz_resolve: got %b want %b", obs, exp); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0, 0, 0);
    tick();
    drive(1, 5'd9, 5'd4, 1, 1, 0, 0, 0, 1, 0, 1);
    exp = 6'b001100; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_pre_stall: got %b want %b", obs, exp); end
    Reset_n = 1'b0; #1;
    exp = 6'b000000; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_mid_stall: got %b want %b", obs, exp); end
    tick();
    Reset_n = 1'b1; #1;
    exp = {5'b00001, FL}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_after_release: got %b want %b", obs, exp); end
    drain();
  endtask

  initial begin
    test_reset();
    test_branch_ex_dep();
    test_load_use();
    test_zero_reg();
    test_branch_priority();
    test_freeze();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
